// File: rtl/rv_pkg.sv
// rv_pkg
//   Shared definitions for the RISC-V IF stage: datapath width, the canonical
//   NOP encoding, the default reset vector and the prefetch entry layout.
//   No ports; imported by fetch_queue and fetch_controller.
package rv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   Small synchronous FIFO of fetch_entry_t used as the IF-stage prefetch
//   buffer.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     push, wdata  write wdata at the tail (accepted when not full, or when a
//                  pop frees the slot in the same cycle)
//     pop          drop the head entry (ignored when empty)
//     flush        discard every entry; overrides push and pop
//     rdata        head entry (meaningful only when !empty)
//     full, empty  occupancy flags
//     count        current occupancy, 0..QDEPTH
module fetch_queue
    import rv_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PTR_W  = $clog2(QDEPTH),
    localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wdata,
    output fetch_entry_t       rdata,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [QDEPTH];
    fetch_entry_t     mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(QDEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop  = pop & ~empty;
        // When full, the slot being written is the head being popped this
        // cycle; the head is read combinationally before the edge, so reuse
        // of the slot is safe.
        do_push = push & (~full | do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                // QDEPTH is a power of two, so pointer overflow is the wrap.
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
//   IF-stage fetch sequencer in front of a combinational instruction ROM.
//   Owns the PC, drives the ROM address, buffers {pc, instr} pairs in a
//   prefetch queue and hands them to decode with a valid/ready handshake.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     en                  fetch enable; low freezes the PC and stops pushes
//     redirect_valid/pc   taken branch/jump from EX; flushes and reloads PC
//     imem_addr           ROM address (the PC register)
//     imem_instr          ROM data for imem_addr
//     id_valid/ready      handshake towards decode
//     id_instr, id_pc     head entry (NOP / 0 when id_valid is low)
//     q_count             prefetch queue occupancy
module fetch_controller
    import rv_pkg::*;
#(
    parameter  logic [31:0] RESET_PC = RESET_VECTOR,
    parameter  int          QDEPTH   = 2,
    localparam int          CNT_W    = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [CNT_W-1:0]  q_count
);

    logic [31:0]  pc_q, pc_d;
    logic         pop, push;
    logic         q_full, q_empty;
    fetch_entry_t head, new_entry;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid),
        .wdata  (new_entry),
        .rdata  (head),
        .full   (q_full),
        .empty  (q_empty),
        .count  (q_count)
    );

    assign imem_addr = pc_q;

    // Head outputs come only from queue storage; the ROM data never reaches
    // decode without first being registered in the queue.
    always_comb begin
        id_valid = ~q_empty;
        id_instr = NOP_INSTR;
        id_pc    = '0;
        if (!q_empty) begin
            id_instr = head.instr;
            id_pc    = head.pc;
        end
    end

    always_comb begin
        pop       = id_valid & id_ready;
        // A pop frees a slot for a same-cycle push even when full.
        push      = en & ~redirect_valid & (~q_full | pop);
        new_entry = '{pc: pc_q, instr: imem_instr};

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + 32'd4;  // wraps naturally at 2^32
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
